// File: rtl/stream_out_pkg.sv
// Shared constants and types for the stream_out_interface bus-to-stream bridge.
package stream_out_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_CONTROL  = 2'd2;
    localparam logic [1:0] ADDR_UNDERRUN = 2'd3;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_BELOW_LOW = 3;
    localparam int ST_LEVEL_LSB = 16;
    localparam int ST_LEVEL_MSB = 27;

    localparam int CTL_RUN    = 0;
    localparam int CTL_FLUSH  = 1;
    localparam int CTL_IRQ_EN = 2;
    localparam int CTL_LW_LSB = 16;
    localparam int CTL_LW_MSB = 27;

    localparam int              LW_W            = CTL_LW_MSB - CTL_LW_LSB + 1;
    localparam logic [LW_W-1:0] LOW_WATER_RESET = LW_W'(256);

    typedef struct packed {
        logic            run;
        logic            irq_en;
        logic [LW_W-1:0] low_water;
    } control_t;

endpackage

// File: rtl/stream_out_fifo.sv
// Sample FIFO for the output bridge; asynchronous read of the head word, and a
// clear that still accepts a same-cycle push into the emptied buffer.
module stream_out_fifo
    import stream_out_pkg::*;
#(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_SIZE-1:0]  push_data,
    input  logic                  pop,
    output logic [DATA_SIZE-1:0]  pop_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign wr_addr  = clear ? '0 : wr_ptr;
    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= push ? ADDR_WIDTH'(1) : '0;
            rd_ptr <= '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_out_interface.sv
// Bus-to-stream bridge: bus writes fill a FIFO drained through a one-word output stage.
// Optional low-watermark interrupt is built when STREAM_OUT_IRQ_EN is defined.
module stream_out_interface
    import stream_out_pkg::*;
#(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          read_data,
    output logic                 sink_valid,
    output logic [DATA_SIZE-1:0] sink_data,
    input  logic                 sink_ready,
    output logic                 irq
);

    // Stream handshake: a word transfers on an edge where sink_valid && sink_ready;
    // while sink_valid && !sink_ready, sink_data and sink_valid hold steady.

    control_t              ctrl;
    logic                  flush_pend;
    logic                  overflow;
    logic [15:0]           underrun;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_SIZE-1:0]  fifo_data;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic [ADDR_WIDTH:0]   level;
    logic                  below_low;
    logic                  data_wr, status_wr, ctrl_wr, underrun_wr, bus_rd;
    logic [31:0]           status_word, ctrl_word;
    logic                  unused_bits;

    assign data_wr     = chipselect && write && (address == ADDR_DATA);
    assign status_wr   = chipselect && write && (address == ADDR_STATUS);
    assign ctrl_wr     = chipselect && write && (address == ADDR_CONTROL);
    assign underrun_wr = chipselect && write && (address == ADDR_UNDERRUN);
    assign bus_rd      = chipselect && read;
    assign unused_bits = ^writedata[31:28];

    // During the flush cycle the FIFO is emptied, so a DATA write is always kept.
    assign fifo_push = data_wr && (!fifo_full || flush_pend);
    assign fifo_pop  = ctrl.run && !fifo_empty && !flush_pend && (!sink_valid || sink_ready);
    assign level     = fifo_count + {{ADDR_WIDTH{1'b0}}, sink_valid};
    assign below_low = (32'(level) < 32'(ctrl.low_water));

    stream_out_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush_pend),
        .push     (fifo_push),
        .push_data(writedata[DATA_SIZE-1:0]),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset || flush_pend) begin
            sink_valid <= 1'b0;
            sink_data  <= '0;
        end else if (fifo_pop) begin
            sink_valid <= 1'b1;
            sink_data  <= fifo_data;
        end else if (sink_valid && sink_ready) begin
            sink_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= '{run: 1'b0, irq_en: 1'b0, low_water: LOW_WATER_RESET};
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= ctrl_wr && writedata[CTL_FLUSH];
            if (ctrl_wr) begin
                ctrl.run       <= writedata[CTL_RUN];
                ctrl.low_water <= writedata[CTL_LW_MSB:CTL_LW_LSB];
`ifdef STREAM_OUT_IRQ_EN
                ctrl.irq_en    <= writedata[CTL_IRQ_EN];
`else
                ctrl.irq_en    <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (status_wr && writedata[ST_OVERFLOW]) begin
            overflow <= 1'b0;
        end else if (data_wr && fifo_full && !flush_pend) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || underrun_wr) begin
            underrun <= '0;
        end else if (ctrl.run && sink_ready && !sink_valid && (underrun != 16'hFFFF)) begin
            underrun <= underrun + 16'd1;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY]     = (level == '0);
        status_word[ST_FULL]      = fifo_full;
        status_word[ST_OVERFLOW]  = overflow;
        status_word[ST_BELOW_LOW] = below_low;
        status_word[ST_LEVEL_MSB:ST_LEVEL_LSB] = LW_W'(level);
        ctrl_word = '0;
        ctrl_word[CTL_RUN]    = ctrl.run;
        ctrl_word[CTL_IRQ_EN] = ctrl.irq_en;
        ctrl_word[CTL_LW_MSB:CTL_LW_LSB] = ctrl.low_water;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
        end else if (bus_rd) begin
            case (address)
                ADDR_STATUS:   read_data <= status_word;
                ADDR_CONTROL:  read_data <= ctrl_word;
                ADDR_UNDERRUN: read_data <= {16'h0000, underrun};
                default:       read_data <= '0;
            endcase
        end
    end

`ifdef STREAM_OUT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= ctrl.irq_en && ctrl.run && below_low;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_stream_out_interface.sv
// Self-checking bench for stream_out_interface: register vector table, directed
// corner sequences and a randomized stream checked against a queue model.
module tb_stream_out_interface;

`ifdef STREAM_OUT_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] read_data;
    logic        sink_valid;
    logic [27:0] sink_data;
    logic        sink_ready = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];

    stream_out_interface dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .read_data (read_data),
        .sink_valid(sink_valid),
        .sink_data (sink_data),
        .sink_ready(sink_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // STATUS word built straight from the register description.
    function automatic logic [31:0] status_exp(input int lvl, input bit full, input bit ovf, input int lw);
        int v;
        v = (lvl << 16) | ((lvl < lw) ? 8 : 0) | (ovf ? 4 : 0) | (full ? 2 : 0) | ((lvl == 0) ? 1 : 0);
        return 32'(v);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = read_data;
    endtask

    task automatic push_burst(input int n, input logic [27:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chipselect = 1'b1; write = 1'b1; address = 2'd0;
            writedata = {4'hF, base + 28'(i)};
        end
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Called at a negedge when a transfer is about to happen on the next edge.
    task automatic take_word();
        logic [27:0] e;
        if (exp_q.size() == 0) begin
            check("stream_extra_word", {4'h0, sink_data}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("stream_data", {4'h0, sink_data}, {4'h0, e});
        end
    endtask

    typedef struct {
        bit          do_write;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] got;
        logic [27:0] held;
        int          acc, prev_lvl, cur_lvl;
        bit          hold_prev, do_wr;
        logic [27:0] hold_data;

        vecs[0] = '{0, 2'd0, 32'h0, 2'd2, 32'h0100_0000, "ctrl_reset"};
        vecs[1] = '{0, 2'd0, 32'h0, 2'd1, status_exp(0, 0, 0, 256), "status_reset"};
        vecs[2] = '{0, 2'd0, 32'h0, 2'd3, 32'h0, "underrun_reset"};
        vecs[3] = '{0, 2'd0, 32'h0, 2'd0, 32'h0, "data_read_zero"};
        vecs[4] = '{1, 2'd2, 32'h0040_0000, 2'd2, 32'h0040_0000, "ctrl_low_water"};
        vecs[5] = '{1, 2'd2, 32'h0040_0006, 2'd2, 32'h0040_0000 | (IRQ_BUILD ? 32'd4 : 32'd0), "ctrl_flush_irq_en"};
        vecs[6] = '{1, 2'd1, 32'h0000_0004, 2'd1, status_exp(0, 0, 0, 64), "status_w1c_idle"};
        vecs[7] = '{1, 2'd2, 32'hF100_0000, 2'd2, 32'h0100_0000, "ctrl_upper_bits"};
        vecs[8] = '{1, 2'd3, 32'h0000_FFFF, 2'd3, 32'h0, "underrun_write_clear"};

        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_sink_valid", {31'd0, sink_valid}, 32'd0);
        check("reset_sink_data", {4'h0, sink_data}, 32'd0);
        check("reset_read_data", read_data, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Register vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_write) bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, got);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Five back-to-back words with run=1 and ready=1
        bus_write(2'd2, 32'h0100_0001);
        sink_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 1 || j == 7) check("seq_valid_low", {31'd0, sink_valid}, 32'd0);
            if (j >= 2 && j <= 6) begin
                check("seq_valid", {31'd0, sink_valid}, 32'd1);
                check("seq_data", {4'h0, sink_data}, 32'(j - 1));
            end
            if (j < 5) begin
                chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'(j + 1);
            end else begin
                chipselect = 1'b0; write = 1'b0;
            end
        end
        sink_ready = 1'b0;

        // Fill to full, overflow, W1C
        bus_write(2'd2, 32'h0100_0000);
        push_burst(2048, 28'h0);
        bus_read(2'd1, got);
        check("status_full", got, status_exp(2048, 1, 0, 256));
        push_burst(1, 28'h0ABCDE);
        bus_read(2'd1, got);
        check("status_overflow", got, status_exp(2048, 1, 1, 256));
        bus_write(2'd1, 32'h0000_0004);
        bus_read(2'd1, got);
        check("status_overflow_w1c", got, status_exp(2048, 1, 0, 256));

        // Flush with run=1, then hold a presented word under backpressure
        bus_write(2'd2, 32'h0100_0003);
        @(negedge clk);
        bus_read(2'd1, got);
        check("flush_status", got, status_exp(0, 0, 0, 256));
        check("flush_sink_valid", {31'd0, sink_valid}, 32'd0);
        held = 28'hABCDEF0;
        push_burst(1, held);
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            check("hold_valid", {31'd0, sink_valid}, 32'd1);
            check("hold_data", {4'h0, sink_data}, {4'h0, held});
            @(negedge clk);
        end
        bus_write(2'd2, 32'h0100_0000);
        check("run_off_valid", {31'd0, sink_valid}, 32'd1);
        check("run_off_data", {4'h0, sink_data}, {4'h0, held});
        sink_ready = 1'b1;
        @(negedge clk);
        check("run_off_accepted", {31'd0, sink_valid}, 32'd0);
        sink_ready = 1'b0;

        // Underrun counting, saturation and clear
        bus_write(2'd2, 32'h0100_0001);
        bus_write(2'd3, 32'h0);
        @(negedge clk);
        sink_ready = 1'b1;
        repeat (20) @(negedge clk);
        sink_ready = 1'b0;
        bus_read(2'd3, got);
        check("underrun_20", got, 32'd20);
        sink_ready = 1'b1;
        repeat (70000) @(negedge clk);
        sink_ready = 1'b0;
        bus_read(2'd3, got);
        check("underrun_saturate", got, 32'h0000_FFFF);
        bus_write(2'd3, 32'h1234_5678);
        bus_read(2'd3, got);
        check("underrun_clear", got, 32'd0);

        // Low-watermark interrupt while draining 300 words
        bus_write(2'd2, 32'h0100_0002);
        @(negedge clk);
        push_burst(300, 28'h100);
        for (int i = 0; i < 300; i++) exp_q.push_back(28'h100 + 28'(i));
        bus_write(2'd2, 32'h0100_0005);
        acc = 0;
        prev_lvl = 300;
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            if (c == 0) sink_ready = 1'b1;
            cur_lvl = 300 - acc;
            check("irq_level", {31'd0, irq}, {31'd0, IRQ_BUILD && (prev_lvl < 256)});
            prev_lvl = cur_lvl;
            if (sink_valid && sink_ready) begin
                take_word();
                acc++;
            end
        end
        sink_ready = 1'b0;
        check("irq_drain_count", 32'(acc), 32'd300);
        bus_read(2'd1, got);
        check("irq_drained_status", got, status_exp(0, 0, 0, 256));

        // Reset mid-stream
        bus_write(2'd2, 32'h0100_0000);
        push_burst(100, 28'h0);
        bus_write(2'd2, 32'h0100_0001);
        @(negedge clk);
        check("pre_reset_valid", {31'd0, sink_valid}, 32'd1);
        bus_read(2'd1, got);
        check("pre_reset_level", got, status_exp(100, 0, 0, 256));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_valid", {31'd0, sink_valid}, 32'd0);
        check("mid_reset_read_data", read_data, 32'd0);
        check("mid_reset_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd1, got);
        check("mid_reset_status", got, status_exp(0, 0, 0, 256));
        bus_read(2'd2, got);
        check("mid_reset_control", got, 32'h0100_0000);

        // Randomized writes and backpressure against the queue model
        bus_write(2'd2, 32'h0100_0001);
        exp_q.delete();
        hold_prev = 1'b0;
        hold_data = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (hold_prev) begin
                check("rand_hold_valid", {31'd0, sink_valid}, 32'd1);
                check("rand_hold_data", {4'h0, sink_data}, {4'h0, hold_data});
            end
            do_wr = 1'($urandom_range(0, 1));
            chipselect = do_wr; write = do_wr; address = 2'd0; writedata = $urandom;
            if (do_wr) exp_q.push_back(writedata[27:0]);
            sink_ready = ($urandom_range(0, 3) != 0);
            if (sink_valid && sink_ready) take_word();
            hold_prev = sink_valid && !sink_ready;
            hold_data = sink_data;
        end
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        if (hold_prev) begin
            check("rand_hold_valid", {31'd0, sink_valid}, 32'd1);
            check("rand_hold_data", {4'h0, sink_data}, {4'h0, hold_data});
        end
        sink_ready = 1'b1;
        for (int c = 0; c < 2100; c++) begin
            if (sink_valid) take_word();
            @(negedge clk);
        end
        sink_ready = 1'b0;
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        bus_read(2'd1, got);
        check("rand_final_status", got, status_exp(0, 0, 0, 256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_out_interface.md
# stream_out_interface

Bus-to-stream bridge for the audio output path, the transmit-side counterpart of the capture bridge. Software writes PCM sample words over the simple bus into an internal DEPTH × DATA_SIZE FIFO. The block drains them as a valid/ready stream toward the audio codec serializer. It also provides status, flush, underrun counting and an optional low-watermark interrupt.

## Interface
- DATA_SIZE, 28, sample word width (≤ 32)
- DEPTH, 2048, FIFO entries (power of two)
- ADDR_WIDTH, $clog2(DEPTH), FIFO pointer width
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- chipselect  in  1  bus select
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 UNDERRUN
- read  in  1  bus read strobe
- write  in  1  bus write strobe
- writedata  in  32  bus write data
- read_data  out  32  registered bus read data
- sink_valid  out  1  stream word available
- sink_data  out  DATA_SIZE  stream word
- sink_ready  in  1  downstream accepts this cycle
- irq  out  1  level interrupt (see Configuration)

## Operation
- DATA write (addr 0), not full: push writedata[DATA_SIZE-1:0]; upper bits ignored. When full: word dropped, STATUS.overflow set (sticky).
- Output stage: one register holding sink_data. It is reloaded from the FIFO when empty, or on the same edge a transfer (sink_valid && sink_ready) occurs, provided the FIFO is non-empty and CONTROL.run=1. Throughput: 1 word/cycle.
- Handshake: sink_data stable and sink_valid held while sink_valid && !sink_ready. Clearing run never drops a presented word; it only blocks new loads.
- level = FIFO count + sink_valid, 0‥DEPTH+1. full = (FIFO count == DEPTH), evaluated on the registered count.
- Simultaneous push and load: FIFO count unchanged. Push while full with a same-cycle pop: push dropped.
- STATUS (addr 1, read):
  - bit0 empty (level==0)
  - bit1 full
  - bit2 overflow
  - bit3 below_low (level < low_water)
  - [27:16] level
  - Write with bit2=1 clears overflow (W1C).
- CONTROL (addr 2, R/W):
  - bit0 run
  - bit1 flush: self-clearing, reads 0
  - bit2 irq_en
  - [27:16] low_water, reset 256
- Flush: on the edge after the write, pointers, count and output register are cleared and sink_valid=0. A DATA write in the same cycle as the flush write is impossible (single bus). A DATA write in the flush-effective cycle is kept.
- UNDERRUN (addr 3): 16-bit counter, incremented each cycle with run && sink_ready && !sink_valid. Saturates at 0xFFFF. Any write clears it; a clear wins over a same-cycle increment.
- Reads of unused bits return 0. Reads of DATA return 0.
- Reset: FIFO empty, sink_valid=0, sink_data=0, read_data=0, irq=0, run=0, irq_en=0, overflow=0, underrun=0, low_water=256.

## Timing
- DATA write sampled at edge k → word stored at k. It is loaded into the output register at k+1, so sink_valid=1 after edge k+1 (run=1, stage empty).
- Register read sampled at edge k → read_data valid after k; held until the next read.
- Status flags reflect state after the most recent edge. level counts the output register.
- irq is registered: one cycle after the level/enable condition changes.
- Reset asserted mid-stream: all state cleared at that edge; sink_valid low the following cycle regardless of sink_ready.

## Configuration
- STREAM_OUT_IRQ_EN defined: irq = registered (irq_en && run && level < low_water). CONTROL.irq_en is R/W.
- Undefined: irq tied 0. CONTROL.irq_en reads 0 and writes are ignored. No irq logic is synthesized.

## Structure
- Package stream_out_pkg:
  - register address localparams
  - STATUS/CONTROL bit-position constants
  - packed control_t typedef (run, irq_en, low_water)
  - reset value of low_water
- Sub-module stream_out_fifo: memory, wr/rd pointers, count, full/empty, push/pop ports. The top holds the output stage, registers, counter and irq.

## Test plan
- run=1, sink_ready=1, write 0x0000001 … 0x0000005 → sink_data 1..5 in order, first sink_valid two edges after first write, then one word per cycle.
- Write 2049 words with run=0 → full=1 after 2048, 2049th dropped, overflow=1, level=2048. W1C to STATUS bit2 → overflow=0.
- run=1, sink_ready held 0 for 10 cycles with one word queued → sink_data unchanged, sink_valid=1 throughout. Clear run → word still presented until accepted.
- run=1, sink_ready=1, FIFO empty for 20 cycles → UNDERRUN reads 20. 70000 cycles → 0xFFFF. Write addr 3 → 0.
- Load 300 words, irq_en=1, low_water=256, drain (STREAM_OUT_IRQ_EN defined) → irq rises one cycle after level drops to 255. Flush → level 0, sink_valid 0. Macro undefined → irq stays 0.
- Reset asserted with 100 words queued and sink_valid=1 → next cycle: level 0, sink_valid 0, read_data 0, CONTROL reads 0x01000000.
